// File: rtl/bus_arb_pkg.sv
// Shared constants for the strict-priority arbiter and its bus grant stage:
// client count, channel addresses and the grant FSM encoding.
package bus_arb_pkg;

  localparam int NUM_CLIENTS = 4;

  localparam logic [1:0] CH_1 = 2'b00;
  localparam logic [1:0] CH_2 = 2'b01;
  localparam logic [1:0] CH_3 = 2'b10;
  localparam logic [1:0] CH_4 = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_GRANT  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_SETTLE = S_SETTLE,
    ST_GRANT  = S_GRANT,
    ST_DONE   = S_DONE
  } state_t;

  function automatic logic [NUM_CLIENTS-1:0] addr_onehot(input logic [1:0] addr);
    return NUM_CLIENTS'(1) << addr;
  endfunction

endpackage

// File: rtl/transfer_watchdog.sv
// Counts GRANT cycles without an acknowledge; expire flags the last allowed cycle.
module transfer_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT_CYCLES > 0) begin : g_wd
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SAT  = '1;

    logic [CW-1:0] cnt;

    // Saturating so a stalled enable can never wrap back below LAST.
    always_ff @(posedge clk) begin
      if (reset || clear) begin
        cnt <= '0;
      end else if (enable && (cnt != SAT)) begin
        cnt <= cnt + CW'(1);
      end
    end

    assign expire = (cnt == LAST);
  end else begin : g_off
    assign expire = 1'b0;
  end

endmodule

// File: rtl/bus_grant_controller.sv
// Grants the shared server bus to the arbiter's winner, holds its data word
// and runs a valid/ack handshake with watchdog abort.
//
//   state  | meaning
//   IDLE   | no transfer; waiting for any client request
//   SETTLE | arbiter output settling; sample winner, confirm its request
//   GRANT  | data held, server_valid high, waiting for server_ack
//   DONE   | one-cycle done/timeout pulse and bus gap
module bus_grant_controller
  import bus_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   client_1_rq,
  input  logic                   client_2_rq,
  input  logic                   client_3_rq,
  input  logic                   client_4_rq,
  input  logic [DATA_WIDTH-1:0]  client_1_data,
  input  logic [DATA_WIDTH-1:0]  client_2_data,
  input  logic [DATA_WIDTH-1:0]  client_3_data,
  input  logic [DATA_WIDTH-1:0]  client_4_data,
  input  logic [1:0]             address_to_be_served,
  input  logic                   server_ack,
  output logic                   server_valid,
  output logic [DATA_WIDTH-1:0]  server_data,
  output logic [1:0]             server_addr,
  output logic [NUM_CLIENTS-1:0] client_grant,
  output logic [NUM_CLIENTS-1:0] client_done,
  output logic                   timeout_err,
  output logic                   busy
);

  state_t                  state;
  logic [1:0]              sel_addr;
  logic [NUM_CLIENTS-1:0]  rq_vec;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    wd_clear;
  logic                    wd_enable;
  logic                    wd_expire;

  assign rq_vec = {client_4_rq, client_3_rq, client_2_rq, client_1_rq};

  always_comb begin
    sel_data = client_1_data;
    case (address_to_be_served)
      CH_1: sel_data = client_1_data;
      CH_2: sel_data = client_2_data;
      CH_3: sel_data = client_3_data;
      CH_4: sel_data = client_4_data;
      default: sel_data = client_1_data;
    endcase
  end

  assign wd_clear  = (state == ST_SETTLE);
  assign wd_enable = (state == ST_GRANT) && !server_ack;

  transfer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      sel_addr     <= '0;
      server_valid <= 1'b0;
      server_data  <= '0;
      server_addr  <= '0;
      client_grant <= '0;
      client_done  <= '0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      client_done <= '0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|rq_vec) begin
            state <= ST_SETTLE;
            busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          sel_addr <= address_to_be_served;
          if (rq_vec[address_to_be_served]) begin
            state        <= ST_GRANT;
            server_data  <= sel_data;
            server_addr  <= address_to_be_served;
            server_valid <= 1'b1;
            client_grant <= addr_onehot(address_to_be_served);
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          // Ack takes precedence over an expiring watchdog on the same edge.
          if (server_ack) begin
            state        <= ST_DONE;
            client_done  <= addr_onehot(sel_addr);
            server_valid <= 1'b0;
            client_grant <= '0;
          end else if (wd_expire) begin
            state        <= ST_DONE;
            timeout_err  <= 1'b1;
            server_valid <= 1'b0;
            client_grant <= '0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_grant_controller.sv
// Scoreboard bench for bus_grant_controller: stimulus queues expected
// transfer outcomes, a negedge monitor pops them on each done/timeout pulse.
module tb_bus_grant_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       c1_rq = 0, c2_rq = 0, c3_rq = 0, c4_rq = 0;
  logic [7:0] c1_data = 0, c2_data = 0, c3_data = 0, c4_data = 0;
  logic [1:0] addr_in = 0;
  logic       ack = 0;
  logic       server_valid;
  logic [7:0] server_data;
  logic [1:0] server_addr;
  logic [3:0] client_grant;
  logic [3:0] client_done;
  logic       timeout_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic       is_timeout;
    int         len;
    logic [3:0] done;
  } exp_t;

  exp_t exp_q[$];

  bus_grant_controller #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .client_1_rq          (c1_rq),
    .client_2_rq          (c2_rq),
    .client_3_rq          (c3_rq),
    .client_4_rq          (c4_rq),
    .client_1_data        (c1_data),
    .client_2_data        (c2_data),
    .client_3_data        (c3_data),
    .client_4_data        (c4_data),
    .address_to_be_served (addr_in),
    .server_ack           (ack),
    .server_valid         (server_valid),
    .server_data          (server_data),
    .server_addr          (server_addr),
    .client_grant         (client_grant),
    .client_done          (client_done),
    .timeout_err          (timeout_err),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] a, input logic [7:0] d, input logic to,
                      input int len, input logic [3:0] dn);
    exp_t e;
    e.addr = a; e.data = d; e.is_timeout = to; e.len = len; e.done = dn;
    exp_q.push_back(e);
  endtask

  // Returns #1 after the edge at which server_valid first appears.
  task automatic wait_valid();
    int n;
    n = 0;
    while (!server_valid && n < 20) begin
      tick();
      n++;
    end
    chk("wait_valid_timeout", {31'd0, server_valid}, 32'd1);
  endtask

  task automatic ack_after(input int len);
    repeat (len - 1) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Monitor: tracks each valid window and scores it on the closing pulse.
  int         vlen = 0;
  logic [7:0] cap_data;
  logic [1:0] cap_addr;
  logic [3:0] cap_grant;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      vlen = 0;
    end else begin
      if (server_valid) begin
        if (vlen == 0) begin
          cap_data = server_data;
          cap_addr = server_addr;
          cap_grant = client_grant;
        end else begin
          chk("data_stable", {24'd0, server_data}, {24'd0, cap_data});
          chk("grant_stable", {28'd0, client_grant}, {28'd0, cap_grant});
        end
        chk("grant_matches_addr", {28'd0, client_grant}, 32'd1 << server_addr);
        vlen++;
      end else begin
        chk("grant_idle_zero", {28'd0, client_grant}, 32'd0);
      end
      if (client_done != 4'd0 || timeout_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {27'd0, timeout_err, client_done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_timeout", {31'd0, timeout_err}, {31'd0, e.is_timeout});
          chk("sb_done", {28'd0, client_done}, {28'd0, e.done});
          chk("sb_addr", {30'd0, cap_addr}, {30'd0, e.addr});
          chk("sb_data", {24'd0, cap_data}, {24'd0, e.data});
          chk("sb_valid_len", vlen, e.len);
        end
        vlen = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    // Reset held with every request high.
    c1_rq = 1; c2_rq = 1; c3_rq = 1; c4_rq = 1;
    c1_data = 8'h5A; addr_in = 2'b00;
    repeat (3) tick();
    chk("rst_valid", {31'd0, server_valid}, 32'd0);
    chk("rst_grant", {28'd0, client_grant}, 32'd0);
    chk("rst_done", {28'd0, client_done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {24'd0, server_data}, 32'd0);
    chk("rst_addr", {30'd0, server_addr}, 32'd0);
    reset = 0;
    push(2'b00, 8'h5A, 1'b0, 1, 4'b0001);
    tick();
    chk("lat_e0_valid", {31'd0, server_valid}, 32'd0);
    chk("lat_e0_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("lat_e1_valid", {31'd0, server_valid}, 32'd1);
    ack = 1; c1_rq = 0; c2_rq = 0; c3_rq = 0; c4_rq = 0;
    tick();
    ack = 0;
    chk("rst_xfer_done", {28'd0, client_done}, 32'd1);
    tick();
    tick();
    chk("rst_xfer_idle", {31'd0, busy}, 32'd0);

    // Single transfer, client 3, ack three cycles after valid.
    c3_rq = 1; c3_data = 8'hA5; addr_in = 2'b10;
    push(2'b10, 8'hA5, 1'b0, 3, 4'b0100);
    tick();
    tick();
    chk("c3_valid", {31'd0, server_valid}, 32'd1);
    chk("c3_addr", {30'd0, server_addr}, 32'd2);
    chk("c3_data", {24'd0, server_data}, 32'h A5);
    chk("c3_grant", {28'd0, client_grant}, 32'h4);
    ack_after(3);
    c3_rq = 0;
    chk("c3_done", {28'd0, client_done}, 32'h4);
    chk("c3_busy_done", {31'd0, busy}, 32'd1);
    tick();
    chk("c3_done_clear", {28'd0, client_done}, 32'd0);
    chk("c3_busy_drop", {31'd0, busy}, 32'd0);

    // Client 2 request withdrawn during SETTLE.
    c2_rq = 1; addr_in = 2'b01;
    tick();
    c2_rq = 0;
    chk("wd_settle_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("wd_no_valid", {31'd0, server_valid}, 32'd0);
    chk("wd_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("wd_no_done", {28'd0, client_done}, 32'd0);

    // Watchdog timeout with ack never asserted; request drop ignored.
    c1_rq = 1; c1_data = 8'h3C; addr_in = 2'b00;
    push(2'b00, 8'h3C, 1'b1, 16, 4'b0000);
    wait_valid();
    c1_rq = 0;
    repeat (15) tick();
    chk("to_still_valid", {31'd0, server_valid}, 32'd1);
    tick();
    chk("to_pulse", {31'd0, timeout_err}, 32'd1);
    chk("to_no_done", {28'd0, client_done}, 32'd0);
    chk("to_valid_drop", {31'd0, server_valid}, 32'd0);
    tick();
    chk("to_pulse_once", {31'd0, timeout_err}, 32'd0);
    chk("to_idle", {31'd0, busy}, 32'd0);

    // Ack on the final watchdog cycle wins over timeout.
    c1_rq = 1; c1_data = 8'hC3;
    push(2'b00, 8'hC3, 1'b0, 16, 4'b0001);
    wait_valid();
    c1_rq = 0;
    ack_after(16);
    chk("last_ack_done", {28'd0, client_done}, 32'd1);
    chk("last_ack_no_to", {31'd0, timeout_err}, 32'd0);
    tick();

    // Back-to-back: clients 1 and 4, client 4 wins first.
    c1_rq = 1; c4_rq = 1; c1_data = 8'h11; c4_data = 8'h44; addr_in = 2'b11;
    push(2'b11, 8'h44, 1'b0, 2, 4'b1000);
    push(2'b00, 8'h99, 1'b0, 2, 4'b0001);
    wait_valid();
    c1_data = 8'h99; c4_data = 8'h77; addr_in = 2'b00;
    tick();
    chk("b2b_data_held", {24'd0, server_data}, 32'h44);
    chk("b2b_addr_held", {30'd0, server_addr}, 32'd3);
    ack = 1; c4_rq = 0;
    tick();
    ack = 0;
    chk("b2b_gap", {31'd0, server_valid}, 32'd0);
    wait_valid();
    chk("b2b_second_grant", {28'd0, client_grant}, 32'd1);
    ack_after(2);
    c1_rq = 0;
    tick();

    // Reset in the middle of GRANT.
    c2_rq = 1; c2_data = 8'h6E; addr_in = 2'b01;
    wait_valid();
    tick();
    reset = 1;
    tick();
    chk("midrst_valid", {31'd0, server_valid}, 32'd0);
    chk("midrst_grant", {28'd0, client_grant}, 32'd0);
    chk("midrst_done", {28'd0, client_done}, 32'd0);
    chk("midrst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 0; c2_rq = 0;
    tick();

    // Ack while idle has no effect.
    ack = 1;
    repeat (3) begin
      tick();
      chk("idle_ack_busy", {31'd0, busy}, 32'd0);
      chk("idle_ack_done", {28'd0, client_done}, 32'd0);
    end
    ack = 0;
    repeat (3) tick();

    chk("sb_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_grant_controller.md
Name: bus_grant_controller

Overview:
Downstream stage of the strict-priority arbiter. It consumes the arbiter's registered address_to_be_served and the raw client requests, and grants the shared server bus to one client at a time. It registers the selected client's data into a one-deep holding register and drives it to the server with a valid/ack handshake. A watchdog aborts transfers the server never acknowledges.

Parameters:
DATA_WIDTH, 8, width of each client data word and of server_data.
TIMEOUT_CYCLES, 16, maximum number of GRANT cycles without server_ack before abort; 0 disables the watchdog.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
client_1_rq .. client_4_rq  input  1  per-client request level, same signals that feed the arbiter
client_1_data .. client_4_data  input  DATA_WIDTH  per-client payload
address_to_be_served  input  2  arbiter winner; 00=client 1 .. 11=client 4
server_ack  input  1  server accepted current word
server_valid  output  1  server_data/server_addr valid
server_data  output  DATA_WIDTH  held payload of granted client
server_addr  output  2  address of granted client
client_grant  output  4  one-hot grant; bit0=client 1
client_done  output  4  one-hot, one-cycle pulse on successful transfer
timeout_err  output  1  one-cycle pulse on watchdog abort
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. At reset, all outputs are 0, the FSM is in IDLE, and the latched address, data and counter are 0. A reset asserted in any state takes effect at the next edge and abandons the transfer without a done or timeout_err pulse.
- FSM states: IDLE, SETTLE, GRANT, DONE.
- IDLE: if any client_x_rq is 1 at an edge, go to SETTLE. SETTLE absorbs the arbiter's one-cycle register latency.
- SETTLE: sample address_to_be_served into sel_addr.
  - If the request of the sampled client is still 1, go to GRANT. In the same edge, capture that client's data into data_hold, set client_grant[sel_addr]=1, server_valid=1 and server_addr=sel_addr, and clear the watchdog counter.
  - Otherwise return to IDLE with no grant.
- GRANT: server_valid stays high, and server_data, server_addr and client_grant stay stable.
  - server_ack=1 at an edge: go to DONE, set client_done[sel_addr]=1, and drop server_valid and client_grant.
  - No ack, and counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES>0): go to DONE, set timeout_err=1, and drop server_valid and client_grant.
  - Otherwise increment the counter.
  - Ack and timeout on the same edge: ack wins.
  - A client dropping its request during GRANT is ignored, because the data is already held.
  - Changes of address_to_be_served during GRANT are ignored.
- DONE: lasts exactly one cycle; the done/timeout pulse is visible here. Always go to IDLE, clearing the pulses. This guarantees a one-cycle bus gap between grants.
- server_ack outside GRANT is ignored.
- Latency: a request present before edge E0 gives SETTLE after E0 and server_valid=1 after E1. With ack sampled at edge Ek, client_done pulses after Ek and busy drops after Ek+1.
- Best-case throughput is one transfer per 4 cycles.
- Watchdog counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- client_grant and client_done are always one-hot or all-zero.

Decomposition:
- Package bus_arb_pkg holds:
  - the NUM_CLIENTS=4 constant;
  - the channel address constants 2'b00..2'b11, shared with the priority logic and priority sort;
  - the FSM state encoding localparams.
- Sub-module transfer_watchdog holds the counter with clear/enable/expire and the TIMEOUT_CYCLES parameter. Everything else stays in the top.

Test Plan:
- Reset: hold reset 3 cycles with all requests high -> all outputs 0 and busy=0. Release reset -> server_valid=1 exactly 2 edges after first sampling a request.
- Single transfer: client 3 requests with data 8'hA5, address 2'b10, ack 3 cycles after valid -> server_addr=2'b10, server_data=8'hA5 and client_grant=4'b0100 for 3 cycles, then client_done=4'b0100 for one cycle, then busy=0 one cycle later.
- Request withdrawn in SETTLE: client 2 pulses request for 1 cycle -> no grant, FSM returns to IDLE, no done pulse.
- Timeout: TIMEOUT_CYCLES=16 with ack never asserted -> server_valid high for exactly 16 cycles, timeout_err pulses once, client_done stays 0.
- Ack on the final watchdog cycle -> client_done pulses and timeout_err stays 0.
- Back-to-back: clients 1 and 4 request continuously, arbiter priority gives client 4 priority 0 -> client 4 is granted. Change client 1 data mid-GRANT -> server_data is unchanged. Next grant follows after the DONE gap, with no overlap of grants.
- Reset mid-GRANT -> all outputs 0 next cycle with no pulses. Ack during IDLE -> no effect.
